// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array: op encodings and saturation limits.
// Limits serve the MAC_SATURATE_EN build of mac_array_pipe.
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_OP_MAC   = 2'b00,
    MAC_OP_LOAD  = 2'b01,
    MAC_OP_MUL   = 2'b10,
    MAC_OP_RDCLR = 2'b11
  } op_t;

  localparam int unsigned LIM_W = 128;

  // Callers truncate to their own accumulator width.
  function automatic logic [LIM_W-1:0] sat_max(input int unsigned acc_w);
    return (LIM_W'(1) << (acc_w - 1)) - LIM_W'(1);
  endfunction

  function automatic logic [LIM_W-1:0] sat_min(input int unsigned acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/mac_acc_bank.sv
// NUM_ACC x ACC_W accumulator register file: one async read port, one write port.
// Write lands on the clock edge; all entries clear on reset.
module mac_acc_bank #(
  parameter int ACC_W   = 40,
  parameter int NUM_ACC = 4,
  parameter int IDX_W   = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [ACC_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ACC_W-1:0] wr_data
);

  logic [ACC_W-1:0] acc_q [NUM_ACC];
  logic [ACC_W-1:0] acc_d [NUM_ACC];

  always_comb begin
    acc_d = acc_q;
    if (wr_en) acc_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rd_data = acc_q[rd_idx];

endmodule

// File: rtl/mac_array_pipe.sv
// Two-stage signed MAC engine with NUM_ACC accumulators; result 2 cycles after request, 1 op/cycle.
// Both stages freeze while out_valid && !out_ready. MAC_SATURATE_EN selects clamping MAC arithmetic.
module mac_array_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int NUM_ACC = 4,
  localparam int IDX_W  = $clog2(NUM_ACC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  rd,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              sat
);

  localparam int PROD_W = 2 * DATA_W;

  logic              adv, accept, fire;
  logic              s1_valid_q, s1_valid_d;
  op_t               s1_op_q, s1_op_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic [ACC_W-1:0]  s1_rs1_q, s1_rs1_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  rd_q, rd_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              sat_q, sat_d;
  logic [ACC_W-1:0]  acc_rdata, prod_ext, mac_res, res, acc_wdata;
  logic              mac_ovf, res_sat, acc_we;

  assign adv      = !out_valid_q || out_ready;
  assign accept   = in_valid && adv;
  assign fire     = adv && s1_valid_q;
  assign prod_ext = ACC_W'($signed(s1_prod_q));

  always_comb begin
    s1_valid_d = adv ? in_valid : s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_idx_d   = s1_idx_q;
    s1_prod_d  = s1_prod_q;
    s1_rs1_d   = s1_rs1_q;
    if (accept) begin
      s1_op_d   = op_t'(in_op);
      s1_idx_d  = in_idx;
      s1_prod_d = PROD_W'($signed(rs1)) * PROD_W'($signed(rs2));
      s1_rs1_d  = ACC_W'($signed(rs1));
    end
  end

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
  logic [ACC_W:0] sum_ext;

  // Overflow when the extra sign bit disagrees with the ACC_W-bit sign.
  always_comb begin
    sum_ext = {acc_rdata[ACC_W-1], acc_rdata} + {prod_ext[ACC_W-1], prod_ext};
    mac_res = sum_ext[ACC_W-1:0];
    mac_ovf = 1'b0;
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
      mac_ovf = 1'b1;
      mac_res = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  always_comb begin
    mac_res = acc_rdata + prod_ext;
    mac_ovf = 1'b0;
  end
`endif

  // The bank write and the output register load share one edge, so the next op sees the new value.
  always_comb begin
    res       = rd_q;
    res_sat   = 1'b0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    case (s1_op_q)
      MAC_OP_MAC: begin
        res       = mac_res;
        res_sat   = mac_ovf;
        acc_we    = 1'b1;
        acc_wdata = mac_res;
      end
      MAC_OP_LOAD: begin
        res       = s1_rs1_q;
        acc_we    = 1'b1;
        acc_wdata = s1_rs1_q;
      end
      MAC_OP_MUL: res = prod_ext;
      MAC_OP_RDCLR: begin
        res    = acc_rdata;
        acc_we = 1'b1;
      end
      default: ;
    endcase
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    rd_d        = fire ? res : rd_q;
    rd_idx_d    = fire ? s1_idx_q : rd_idx_q;
    sat_d       = fire ? res_sat : sat_q;
  end

  mac_acc_bank #(
    .ACC_W   (ACC_W),
    .NUM_ACC (NUM_ACC),
    .IDX_W   (IDX_W)
  ) u_acc_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (s1_idx_q),
    .rd_data (acc_rdata),
    .wr_en   (fire && acc_we),
    .wr_idx  (s1_idx_q),
    .wr_data (acc_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= MAC_OP_MAC;
      s1_idx_q    <= '0;
      s1_prod_q   <= '0;
      s1_rs1_q    <= '0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      rd_idx_q    <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_idx_q    <= s1_idx_d;
      s1_prod_q   <= s1_prod_d;
      s1_rs1_q    <= s1_rs1_d;
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
      rd_idx_q    <= rd_idx_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign rd_idx    = rd_idx_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_array_pipe.sv
// Directed bench for mac_array_pipe (DATA_W=16, ACC_W=32) with an in-order scoreboard.
// Expected results follow MAC_SATURATE_EN when it is defined for the build.
module tb_mac_array_pipe;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NA = 4;
  localparam int IW = 2;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, sat;
  logic [1:0]    in_op;
  logic [IW-1:0] in_idx, rd_idx;
  logic [DW-1:0] rs1, rs2;
  logic [AW-1:0] rd;

  typedef struct {
    logic [AW-1:0] rd;
    logic [IW-1:0] idx;
    logic          sat;
  } exp_t;

  exp_t          sb[$];
  longint        acc_m[NA];
  int            n_assert = 0;
  int            n_fail = 0;
  int            n_out = 0;
  int            base;
  logic [AW-1:0] last_rd, held_rd;
  logic [IW-1:0] held_idx;
  logic          last_sat;

  mac_array_pipe #(.DATA_W(DW), .ACC_W(AW), .NUM_ACC(NA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_idx    (in_idx),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .rd_idx    (rd_idx),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrapv(input longint v);
    longint m;
    m = v & ((64'sd1 <<< AW) - 1);
    if (m[AW-1]) m = m - (64'sd1 <<< AW);
    return m;
  endfunction

  // Scoreboard consumer: a transfer completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_output: observed rd 0x%0h expected no output", rd);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rd", 64'(rd), 64'(e.rd));
        check("sb_idx", 64'(rd_idx), 64'(e.idx));
        check("sb_sat", 64'(sat), 64'(e.sat));
        last_rd  = rd;
        last_sat = sat;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int idx, input int a, input int b);
    exp_t   e;
    longint p, s;
    bit     ok;
    in_valid = 1'b1;
    in_op    = op;
    in_idx   = idx[IW-1:0];
    rs1      = a[DW-1:0];
    rs2      = b[DW-1:0];
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL accept_timeout: observed in_ready 0 expected 1 within 100 cycles");
    end
    p = longint'(a) * longint'(b);
    e.sat = 1'b0;
    e.idx = idx[IW-1:0];
    case (op)
      2'b00: begin
        s = acc_m[idx] + p;
`ifdef MAC_SATURATE_EN
        if (s > MAXV) begin s = MAXV; e.sat = 1'b1; end
        else if (s < MINV) begin s = MINV; e.sat = 1'b1; end
`else
        s = wrapv(s);
`endif
        acc_m[idx] = s;
      end
      2'b01: begin s = a; acc_m[idx] = s; end
      2'b10: s = wrapv(p);
      default: begin s = acc_m[idx]; acc_m[idx] = 0; end
    endcase
    e.rd = s[AW-1:0];
    if (ok) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_idx    = '0;
    rs1       = '0;
    rs2       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NA; i++) acc_m[i] = 0;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_rd_idx", 64'(rd_idx), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single MAC: result one edge after the accepting edge.
    issue(2'b00, 0, 3, 4);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_rd", 64'(rd), 64'd12);
    check("lat_idx", 64'(rd_idx), 64'd0);
    drain();

    // Back-to-back on one accumulator, then read-and-clear.
    issue(2'b00, 1, -2, 5);
    issue(2'b00, 1, 7, 7);
    issue(2'b11, 1, 0, 0);
    issue(2'b00, 1, 1, 1);
    drain();
    check("b2b_last_rd", 64'(last_rd), 64'd1);

    // LOAD / MUL / MAC interleave; MUL must not disturb acc2.
    issue(2'b01, 2, -100, 0);
    issue(2'b10, 2, 6, -6);
    issue(2'b00, 2, 10, 10);
    drain();
    check("mix_last_rd", 64'(last_rd), 64'd0);

    // Backpressure with three ops outstanding.
    base = n_out;
    out_ready = 1'b0;
    issue(2'b01, 0, 5, 0);
    issue(2'b10, 1, 3, -3);
    held_rd  = rd;
    held_idx = rd_idx;
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_idx   = 2'd0;
    rs1      = 16'd2;
    rs2      = 16'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_rd", 64'(rd), 64'(held_rd));
      check("stall_idx", 64'(rd_idx), 64'(held_idx));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(2'b00, 0, 2, 2);
    drain();
    check("stall_count", 64'(n_out - base), 64'd3);
    check("stall_last_rd", 64'(last_rd), 64'd9);

    // Overflow of the accumulator: saturate or wrap depending on build.
    issue(2'b01, 3, 32767, 0);
    repeat (3) issue(2'b00, 3, 32767, 32767);
    drain();
`ifdef MAC_SATURATE_EN
    check("ovf_rd", 64'(last_rd), 64'h7FFF_FFFF);
    check("ovf_sat", 64'(last_sat), 64'd1);
`else
    check("ovf_rd", 64'(last_rd), 64'hBFFD_8002);
    check("ovf_sat", 64'(last_sat), 64'd0);
`endif

    // Reset with two ops in flight.
    issue(2'b00, 0, 1, 1);
    issue(2'b00, 1, 2, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rd", 64'(rd), 64'd0);
    sb.delete();
    for (int i = 0; i < NA; i++) acc_m[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    base = n_out;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NA; i++) issue(2'b11, i, 0, 0);
    drain();
    check("post_rst_count", 64'(n_out - base), 64'(NA));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
